// File: rtl/vga_pkg.sv
// ----------------------------------------------------------------------------
// vga_pkg
// Shared definitions for the VGA sync monitor: the bit positions of the
// per-frame error flags and the monitor FSM state encoding.
// No ports (package only).
// ----------------------------------------------------------------------------
package vga_pkg;

    // Bit positions inside the 4-bit frame error vector
    localparam int ERR_HACTIVE = 0;
    localparam int ERR_HTOTAL  = 1;
    localparam int ERR_VACTIVE = 2;
    localparam int ERR_VTOTAL  = 3;

    // Monitor FSM states
    typedef enum logic [1:0] {
        ST_SEEK   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_BLANK  = 2'd2
    } state_t;

endpackage

// File: rtl/vga_edge_detect.sv
// ----------------------------------------------------------------------------
// vga_edge_detect
// Registers one sync input and produces single-cycle rise and fall pulses.
// The pulses compare the live input against its one-cycle-old copy, so they
// are asserted in the same cycle the new level is first seen.
// Ports:
//   i_Clk   - pixel clock
//   i_Rst_L - asynchronous active-low reset
//   i_Sync  - sync input to watch
//   o_Rise  - high for the cycle in which i_Sync is first seen high
//   o_Fall  - high for the cycle in which i_Sync is first seen low
// ----------------------------------------------------------------------------
module vga_edge_detect (
    input  logic i_Clk,
    input  logic i_Rst_L,
    input  logic i_Sync,
    output logic o_Rise,
    output logic o_Fall
);

    logic r_Sync;

    // Previous-cycle copy of the sync input
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            r_Sync <= 1'b0;
        end else begin
            r_Sync <= i_Sync;
        end
    end

    assign o_Rise = i_Sync & ~r_Sync;
    assign o_Fall = ~i_Sync & r_Sync;

endmodule

// File: rtl/vga_sync_monitor.sv
// ----------------------------------------------------------------------------
// vga_sync_monitor
// Watches the HSync/VSync/RGB stream from the test-pattern stage, checks
// line and frame geometry, computes a 16-bit rotate-xor checksum over every
// frame's active pixels and issues one report per frame plus a lock flag.
// Ports:
//   i_Clk, i_Rst_L            - pixel clock, asynchronous active-low reset
//   i_HSync, i_VSync          - syncs, high during active columns / rows
//   i_Red/Grn/Blu_Video       - colour channels, sampled with the syncs
//   o_Frame_Valid             - one-cycle pulse when a report is presented
//   o_Frame_CRC, o_Frame_Err  - checksum and error flags of reported frame
//   o_Frame_Count             - number of reports issued (wraps)
//   o_Locked                  - LOCK_FRAMES consecutive clean reports seen
// ----------------------------------------------------------------------------
module vga_sync_monitor
    import vga_pkg::*;
#(
    parameter int VIDEO_WIDTH = 3,
    parameter int TOTAL_COLS  = 800,
    parameter int TOTAL_ROWS  = 525,
    parameter int ACTIVE_COLS = 640,
    parameter int ACTIVE_ROWS = 480,
    parameter int LOCK_FRAMES = 2
) (
    input  logic                   i_Clk,
    input  logic                   i_Rst_L,
    input  logic                   i_HSync,
    input  logic                   i_VSync,
    input  logic [VIDEO_WIDTH-1:0] i_Red_Video,
    input  logic [VIDEO_WIDTH-1:0] i_Grn_Video,
    input  logic [VIDEO_WIDTH-1:0] i_Blu_Video,
    output logic                   o_Frame_Valid,
    output logic [15:0]            o_Frame_CRC,
    output logic [3:0]             o_Frame_Err,
    output logic [15:0]            o_Frame_Count,
    output logic                   o_Locked
);

    // Counters get one spare state beyond their saturation value
    localparam int COL_MAX = 2 * TOTAL_COLS;
    localparam int ROW_MAX = 2 * TOTAL_ROWS;
    localparam int WD_MAX  = 2 * TOTAL_COLS * TOTAL_ROWS;
    localparam int COL_W   = $clog2(COL_MAX + 1);
    localparam int ROW_W   = $clog2(ROW_MAX + 1);
    localparam int WD_W    = $clog2(WD_MAX + 1);
    localparam int GOOD_W  = $clog2(LOCK_FRAMES + 1);

    localparam logic [COL_W-1:0]  COL_SAT    = COL_W'(COL_MAX);
    localparam logic [COL_W-1:0]  ACT_COLS_C = COL_W'(ACTIVE_COLS);
    localparam logic [COL_W-1:0]  TOT_COLS_C = COL_W'(TOTAL_COLS);
    localparam logic [ROW_W-1:0]  ROW_SAT    = ROW_W'(ROW_MAX);
    localparam logic [ROW_W-1:0]  ACT_ROWS_C = ROW_W'(ACTIVE_ROWS);
    localparam logic [ROW_W-1:0]  TOT_ROWS_C = ROW_W'(TOTAL_ROWS);
    localparam logic [WD_W-1:0]   WD_SAT     = WD_W'(WD_MAX);
    localparam logic [GOOD_W-1:0] GOOD_SAT   = GOOD_W'(LOCK_FRAMES);

    state_t             state, state_next;
    logic               h_rise, h_fall, v_rise, v_fall;
    logic               pix_active, in_frame;
    logic [15:0]        pix_word, crc, crc_next;
    logic [COL_W-1:0]   col_cnt;
    logic [ROW_W-1:0]   line_cnt, act_lines;
    logic [WD_W-1:0]    wd_cnt;
    logic [GOOD_W-1:0]  good_cnt;
    logic [3:0]         err_acc, err_now, report_err;
    logic               skip_h, start_frame, report, timeout;

    vga_edge_detect u_hsync_edge (
        .i_Clk   (i_Clk),
        .i_Rst_L (i_Rst_L),
        .i_Sync  (i_HSync),
        .o_Rise  (h_rise),
        .o_Fall  (h_fall)
    );

    vga_edge_detect u_vsync_edge (
        .i_Clk   (i_Clk),
        .i_Rst_L (i_Rst_L),
        .i_Sync  (i_VSync),
        .o_Rise  (v_rise),
        .o_Fall  (v_fall)
    );

    assign pix_active = i_HSync & i_VSync;
    assign in_frame   = (state != ST_SEEK);
    assign pix_word   = 16'({i_Red_Video, i_Grn_Video, i_Blu_Video});
    assign crc_next   = {crc[14:0], crc[15]} ^ pix_word;
    assign o_Locked   = (good_cnt == GOOD_SAT);

    // State register
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state <= ST_SEEK;
        end else begin
            state <= state_next;
        end
    end

    // Next state plus the frame start / report / timeout strobes.
    // A V-rise while still in ST_ACTIVE means VSync dropped and came back
    // between samples, so it closes the frame exactly like one in ST_BLANK.
    // The watchdog overrides everything and abandons the frame silently.
    always_comb begin
        state_next  = state;
        start_frame = 1'b0;
        report      = 1'b0;
        timeout     = 1'b0;
        case (state)
            ST_SEEK: begin
                if (v_rise) begin
                    start_frame = 1'b1;
                    state_next  = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                if (v_rise) begin
                    report      = 1'b1;
                    start_frame = 1'b1;
                end else if (v_fall) begin
                    state_next = ST_BLANK;
                end
            end
            ST_BLANK: begin
                if (v_rise) begin
                    report      = 1'b1;
                    start_frame = 1'b1;
                    state_next  = ST_ACTIVE;
                end
            end
            default: state_next = ST_SEEK;
        endcase
        if (in_frame && (wd_cnt == WD_SAT)) begin
            timeout     = 1'b1;
            report      = 1'b0;
            start_frame = 1'b0;
            state_next  = ST_SEEK;
        end
    end

    // Errors detected this cycle. The column count at an H-rise measures the
    // line that just ended, so a H-rise coincident with the closing V-rise
    // still belongs to the frame being reported.
    always_comb begin
        err_now              = '0;
        err_now[ERR_HACTIVE] = in_frame & h_fall & (col_cnt != ACT_COLS_C);
        err_now[ERR_HTOTAL]  = in_frame & h_rise & ~skip_h & (col_cnt != TOT_COLS_C);
        err_now[ERR_VACTIVE] = (state == ST_ACTIVE) & v_fall & (act_lines != ACT_ROWS_C);
        report_err             = err_acc | err_now;
        report_err[ERR_VTOTAL] = line_cnt != TOT_ROWS_C;
    end

    // Datapath: column/line counters, checksum, error accumulation, watchdog,
    // lock counter and report outputs. skip_h covers a frame acquired without
    // a coincident H-rise, where the first measured line length is garbage.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            col_cnt       <= '0;
            line_cnt      <= '0;
            act_lines     <= '0;
            crc           <= '0;
            err_acc       <= '0;
            wd_cnt        <= '0;
            good_cnt      <= '0;
            skip_h        <= 1'b0;
            o_Frame_Valid <= 1'b0;
            o_Frame_CRC   <= '0;
            o_Frame_Err   <= '0;
            o_Frame_Count <= '0;
        end else begin
            o_Frame_Valid <= report;

            if (h_rise) begin
                col_cnt <= COL_W'(1);
            end else if (col_cnt != COL_SAT) begin
                col_cnt <= col_cnt + COL_W'(1);
            end

            if (h_rise) begin
                skip_h <= 1'b0;
            end
            if (start_frame && (state == ST_SEEK)) begin
                skip_h <= ~h_rise;
            end

            if (timeout) begin
                wd_cnt   <= '0;
                good_cnt <= '0;
            end else if (start_frame) begin
                crc       <= pix_active ? pix_word : 16'h0000;
                line_cnt  <= h_rise ? ROW_W'(1) : '0;
                act_lines <= h_rise ? ROW_W'(1) : '0;
                err_acc   <= '0;
                wd_cnt    <= '0;
            end else if (in_frame) begin
                if (pix_active) begin
                    crc <= crc_next;
                end
                if (h_rise && (line_cnt != ROW_SAT)) begin
                    line_cnt <= line_cnt + ROW_W'(1);
                end
                if (h_rise && i_VSync && (act_lines != ROW_SAT)) begin
                    act_lines <= act_lines + ROW_W'(1);
                end
                err_acc <= err_acc | err_now;
                if (wd_cnt != WD_SAT) begin
                    wd_cnt <= wd_cnt + WD_W'(1);
                end
            end

            if (report) begin
                o_Frame_CRC   <= crc;
                o_Frame_Err   <= report_err;
                o_Frame_Count <= o_Frame_Count + 16'd1;
                if (report_err == 4'd0) begin
                    if (good_cnt != GOOD_SAT) begin
                        good_cnt <= good_cnt + GOOD_W'(1);
                    end
                end else begin
                    good_cnt <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_vga_sync_monitor.sv
// ----------------------------------------------------------------------------
// tb_vga_sync_monitor
// Drives frames of a small 10x6 raster (8x4 active) into vga_sync_monitor.
// Each frame is described by a table record holding its geometry and the
// error flags it should produce; the expected checksum is folded up from the
// pixels actually driven, and the lock/count expectations come from a simple
// frame-level model. Reports are checked by a negedge monitor.
// ----------------------------------------------------------------------------
module tb_vga_sync_monitor;

    localparam int VW = 3;
    localparam int TC = 10;
    localparam int TR = 6;
    localparam int AC = 8;
    localparam int AR = 4;
    localparam int LF = 2;

    logic          i_Clk;
    logic          i_Rst_L;
    logic          i_HSync;
    logic          i_VSync;
    logic [VW-1:0] i_Red_Video;
    logic [VW-1:0] i_Grn_Video;
    logic [VW-1:0] i_Blu_Video;
    logic          o_Frame_Valid;
    logic [15:0]   o_Frame_CRC;
    logic [3:0]    o_Frame_Err;
    logic [15:0]   o_Frame_Count;
    logic          o_Locked;

    vga_sync_monitor #(
        .VIDEO_WIDTH (VW),
        .TOTAL_COLS  (TC),
        .TOTAL_ROWS  (TR),
        .ACTIVE_COLS (AC),
        .ACTIVE_ROWS (AR),
        .LOCK_FRAMES (LF)
    ) dut (
        .i_Clk         (i_Clk),
        .i_Rst_L       (i_Rst_L),
        .i_HSync       (i_HSync),
        .i_VSync       (i_VSync),
        .i_Red_Video   (i_Red_Video),
        .i_Grn_Video   (i_Grn_Video),
        .i_Blu_Video   (i_Blu_Video),
        .o_Frame_Valid (o_Frame_Valid),
        .o_Frame_CRC   (o_Frame_CRC),
        .o_Frame_Err   (o_Frame_Err),
        .o_Frame_Count (o_Frame_Count),
        .o_Locked      (o_Locked)
    );

    // Pixel clock
    initial begin
        i_Clk = 1'b0;
        forever #5 i_Clk = ~i_Clk;
    end

    // mode: 0 constant 9'h1FF, 1 column bars, 2 random pixels
    typedef struct {
        int         mode;
        int         glitch_row;
        int         vrows;
        int         nrows;
        logic [3:0] exp_err;
        logic       chk_diff;
    } frame_vec_t;

    typedef struct {
        logic [15:0] crc;
        logic [3:0]  err;
        logic [15:0] count;
        logic        locked;
        logic        chk_diff;
    } report_t;

    frame_vec_t  tbl [12];
    frame_vec_t  partial;
    report_t     expq [$];
    int          compare_count = 0;
    int          fail_count    = 0;
    bit          pending;
    logic [15:0] pend_crc;
    logic [3:0]  pend_err;
    logic        pend_diff;
    int          lock_model;
    logic [15:0] exp_count;
    logic [15:0] clean_crc;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        compare_count++;
        if (actual !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got 0x%0h, wanted 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Present one cycle of video; returns just after the sampling edge
    task automatic applyStimulus(input logic h, input logic v, input logic [8:0] pix);
        i_HSync     = h;
        i_VSync     = v;
        i_Red_Video = pix[8:6];
        i_Grn_Video = pix[5:3];
        i_Blu_Video = pix[2:0];
        @(posedge i_Clk);
        #1;
    endtask

    function automatic logic [8:0] bar_pix(input int c, input int r, input int f);
        int v;
        v = (c * 57 + f * 13 + r) % 512;
        return 9'(v);
    endfunction

    // A frame closed by a V-rise turns into one expected report
    task automatic push_report();
        report_t e;
        exp_count = exp_count + 16'd1;
        if (pend_err == 4'd0) begin
            if (lock_model < LF) lock_model++;
        end else begin
            lock_model = 0;
        end
        e.crc      = pend_crc;
        e.err      = pend_err;
        e.count    = exp_count;
        e.locked   = (lock_model == LF);
        e.chk_diff = pend_diff;
        expq.push_back(e);
        pending = 0;
    endtask

    task automatic drive_frame(input frame_vec_t f, input int fidx);
        logic [15:0] crc;
        logic [8:0]  pix;
        logic [31:0] rnd;
        logic        h, v;
        int          len, hlen;
        crc = 16'h0000;
        for (int r = 0; r < f.nrows; r++) begin
            len  = (r == f.glitch_row) ? TC - 1 : TC;
            hlen = (r == f.glitch_row) ? AC - 1 : AC;
            for (int c = 0; c < len; c++) begin
                h = (c < hlen);
                v = (r < f.vrows);
                if (r == 0 && c == 0 && pending) push_report();
                rnd = $urandom;
                if (h && v) begin
                    case (f.mode)
                        0:       pix = 9'h1FF;
                        1:       pix = bar_pix(c, r, fidx);
                        default: pix = rnd[8:0];
                    endcase
                    crc = {crc[14:0], crc[15]} ^ {7'b0, pix};
                end else begin
                    pix = rnd[8:0];
                end
                applyStimulus(h, v, pix);
            end
        end
        pending   = 1;
        pend_crc  = crc;
        pend_err  = f.exp_err;
        pend_diff = f.chk_diff;
        if (fidx == 0) clean_crc = crc;
    endtask

    // Blanking lines with VSync low; optionally releases reset mid-way
    task automatic drive_idle(input int n, input int release_at);
        logic [31:0] rnd;
        for (int k = 0; k < n; k++) begin
            if (k == release_at) i_Rst_L = 1'b1;
            rnd = $urandom;
            applyStimulus((k % TC) < AC, 1'b0, rnd[8:0]);
        end
    endtask

    task automatic check_reset_zero();
        checkOutput("rst_valid",  {31'b0, o_Frame_Valid}, 32'd0);
        checkOutput("rst_crc",    {16'b0, o_Frame_CRC},   32'd0);
        checkOutput("rst_err",    {28'b0, o_Frame_Err},   32'd0);
        checkOutput("rst_count",  {16'b0, o_Frame_Count}, 32'd0);
        checkOutput("rst_locked", {31'b0, o_Locked},      32'd0);
    endtask

    // Report monitor, sampling away from the active edge
    always @(negedge i_Clk) begin
        report_t e;
        if (i_Rst_L && o_Frame_Valid) begin
            if (expq.size() == 0) begin
                compare_count++;
                fail_count++;
                $display("[TB] FAIL unexpected_report: got count 0x%0h, wanted no report at %0t", o_Frame_Count, $time);
            end else begin
                e = expq.pop_front();
                checkOutput("report_crc",    {16'b0, o_Frame_CRC},   {16'b0, e.crc});
                checkOutput("report_err",    {28'b0, o_Frame_Err},   {28'b0, e.err});
                checkOutput("report_count",  {16'b0, o_Frame_Count}, {16'b0, e.count});
                checkOutput("report_locked", {31'b0, o_Locked},      {31'b0, e.locked});
                if (e.chk_diff) begin
                    compare_count++;
                    if (o_Frame_CRC == clean_crc) begin
                        fail_count++;
                        $display("[TB] FAIL crc_differs: got 0x%0h, wanted anything but 0x%0h", o_Frame_CRC, clean_crc);
                    end
                end
            end
        end
    end

    initial begin
        tbl[0]  = '{0, -1, 4, 6, 4'b0000, 1'b0};
        tbl[1]  = '{0, -1, 4, 6, 4'b0000, 1'b0};
        tbl[2]  = '{0, -1, 4, 6, 4'b0000, 1'b0};
        tbl[3]  = '{0,  1, 4, 6, 4'b0011, 1'b0};
        tbl[4]  = '{0, -1, 4, 6, 4'b0000, 1'b0};
        tbl[5]  = '{0, -1, 4, 6, 4'b0000, 1'b0};
        tbl[6]  = '{0, -1, 3, 5, 4'b1100, 1'b1};
        tbl[7]  = '{1, -1, 4, 6, 4'b0000, 1'b0};
        tbl[8]  = '{1, -1, 4, 6, 4'b0000, 1'b0};
        tbl[9]  = '{1, -1, 4, 6, 4'b0000, 1'b0};
        tbl[10] = '{2, -1, 4, 6, 4'b0000, 1'b0};
        tbl[11] = '{2, -1, 4, 6, 4'b0000, 1'b0};
        partial = '{0, -1, 4, 5, 4'b0000, 1'b0};

        pending    = 0;
        lock_model = 0;
        exp_count  = 16'd0;
        clean_crc  = 16'd0;
        pend_crc   = 16'd0;
        pend_err   = 4'd0;
        pend_diff  = 1'b0;
        i_Rst_L     = 1'b0;
        i_HSync     = 1'b0;
        i_VSync     = 1'b0;
        i_Red_Video = '0;
        i_Grn_Video = '0;
        i_Blu_Video = '0;

        repeat (2) @(posedge i_Clk);
        #1;
        check_reset_zero();
        i_Rst_L = 1'b1;

        // Clean, glitched, short-frame, bars and random frames
        for (int i = 0; i < 12; i++) begin
            drive_frame(tbl[i], i);
        end

        // Reset in the blanking of a frame: partial frame is discarded
        drive_frame(partial, 20);
        #2;
        i_Rst_L = 1'b0;
        #1;
        check_reset_zero();
        pending    = 0;
        lock_model = 0;
        exp_count  = 16'd0;
        drive_idle(10, 3);
        checkOutput("queue_after_reset", expq.size(), 32'd0);
        drive_frame(tbl[0], 21);
        checkOutput("count_after_first_vrise", {16'b0, o_Frame_Count}, 32'd0);
        drive_frame(tbl[0], 22);
        drive_frame(tbl[0], 23);
        drive_frame(tbl[0], 24);

        // VSync stuck low after lock: watchdog drops lock, no report
        drive_idle(40, -1);
        checkOutput("locked_before_watchdog", {31'b0, o_Locked}, 32'd1);
        drive_idle(30, -1);
        checkOutput("locked_after_watchdog", {31'b0, o_Locked}, 32'd0);
        checkOutput("count_after_watchdog", {16'b0, o_Frame_Count}, {16'b0, exp_count});
        pending    = 0;
        lock_model = 0;

        // Reacquire after the watchdog
        drive_frame(tbl[7], 30);
        drive_frame(tbl[10], 31);
        drive_frame(tbl[0], 32);
        drive_frame(tbl[0], 33);
        drive_idle(5, -1);
        checkOutput("reports_outstanding", expq.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, fail_count);
        $finish;
    end

endmodule
